pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction fetch for the 5-stage pipeline.
- Arbitrates between these next-PC sources: reset vector, branch redirect (resolved in ID by the branch-condition logic), halt, hazard stall, instruction-memory wait, and sequential increment.
- Produces the fetch address, PC+2 for link/IF-ID, a one-cycle flush pulse for IF/ID, and a sticky halted indication.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- PC_STEP, 2, byte increment per sequential instruction.
- WAIT_MAX, 15, cycles of imem_ready low before mem_timeout asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hazard-unit stall; hold PC.
- br_valid  input  1  branch instruction resolved in ID this cycle.
- br_taken  input  1  condition met (meaningful only with br_valid).
- br_target  input  16  redirect address (PC+2+offset<<1, or register for BR).
- hlt_dec  input  1  HLT opcode decoded in ID.
- imem_ready  input  1  instruction memory has data for pc_out.
- pc_out  output  16  current fetch address.
- pc_plus2  output  16  pc_out + PC_STEP, combinational, wraps mod 2^16.
- fetch_valid  output  1  IF/ID may capture the instruction this cycle.
- flush  output  1  squash IF/ID contents; one-cycle pulse.
- halted  output  1  sticky; processor stopped.
- mem_timeout  output  1  sticky; imem wait exceeded WAIT_MAX.

Behaviour:
- Reset (rst_n low, async):
  - pc_out=RESET_PC; state=BOOT.
  - flush=0, halted=0, mem_timeout=0, wait counter=0.
  - fetch_valid=0 while in reset.
- States: BOOT, RUN, WAIT, HALT.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts; fetch_valid=0; PC held.
  - Next state is RUN.
- RUN: next-PC priority, highest first:
  1. br_valid&br_taken: pc<=br_target; flush=1 next cycle; branch overrides stall, imem wait and hlt_dec (the halt being squashed is wrong-path).
  2. hlt_dec: pc held; state<=HALT.
  3. stall: pc held; fetch_valid=0.
  4. !imem_ready: pc held; state<=WAIT; wait counter<=1.
  5. Otherwise: pc<=pc_plus2; fetch_valid=1.
- br_valid with br_taken=0 is not a redirect; fall through to items 2–5.
- WAIT:
  - Counter increments each cycle imem_ready=0; saturates at WAIT_MAX.
  - When the counter reaches WAIT_MAX, mem_timeout<=1 (sticky until reset).
  - imem_ready=1 returns to RUN and clears the counter; the fetch completes that cycle (fetch_valid=1, pc<=pc_plus2) unless stall is high.
  - A taken branch in WAIT redirects and returns to RUN (abandons the pending fetch).
- HALT:
  - pc frozen at the HLT address; halted=1 from the cycle after entry.
  - fetch_valid=0; all other inputs ignored; exits only on reset.
- flush:
  - Registered; high exactly one cycle after each accepted redirect.
  - Back-to-back redirects give back-to-back pulses.
- fetch_valid is combinational from state and inputs: high only in RUN (or WAIT with imem_ready) with no stall and no taken redirect.
- Wrap-around:
  - 16'hFFFE+2 -> 16'h0000; no error flagged.
  - br_target bit 0 is forced to 0 on load.
- Reset mid-operation (any state, including WAIT or HALT) returns to BOOT immediately and clears all sticky flags.

Test Plan:
- Reset then 4 idle cycles, imem_ready=1 -> BOOT 1 cycle, pc 0x0000, 0x0002, 0x0004; fetch_valid=0 in BOOT, then 1.
- At pc=0x0010, br_valid=1, br_taken=1, br_target=0x0101, stall=1 -> next pc=0x0100, flush=1 for one cycle, stall ignored.
- br_taken and hlt_dec together at pc=0x0020, target 0x0040 -> pc=0x0040, no halt; then hlt_dec alone -> pc frozen at 0x0042, halted=1 next cycle and stays set through 10 cycles of branches and stalls.
- imem_ready low 3 cycles at pc=0x0030 -> pc held, state WAIT, fetch_valid=0, mem_timeout=0; ready high -> pc=0x0032. Repeat with 16 cycles low -> mem_timeout=1 and remains 1 after ready returns.
- pc=0xFFFE, sequential fetch -> pc=0x0000; stall held 5 cycles -> pc unchanged, fetch_valid=0 throughout.
- rst_n pulsed low mid-WAIT with mem_timeout=1, and separately in HALT -> outputs reset asynchronously (pc=RESET_PC, flags 0) before the next clk edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and picks the next PC each cycle from
// the reset vector, a taken branch, a halt, a hazard stall, an imem wait or
// the sequential increment. Also drives the IF/ID flush pulse, the sticky
// halted flag and the sticky imem-timeout flag.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2,
    parameter int          WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        hlt_dec,
    input  logic        imem_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        fetch_valid,
    output logic        flush,
    output logic        halted,
    output logic        mem_timeout
);

    localparam int             CW   = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  WMAX = CW'(WAIT_MAX);

    typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_e;

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;

    logic            redirect;
    logic [15:0]     tgt;

    // Only a taken branch redirects; a resolved not-taken branch falls through.
    assign redirect = br_valid & br_taken;
    // Instructions are halfword aligned, so the low address bit is dropped.
    assign tgt      = {br_target[15:1], 1'b0};

    assign pc_plus2    = pc_q + 16'(PC_STEP);
    assign pc_out      = pc_q;
    assign flush       = flush_q;
    assign halted      = halted_q;
    assign mem_timeout = timeout_q;

    // Next-state / next-PC selection and the combinational fetch_valid.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        flush_d     = 1'b0;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        fetch_valid = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    // Overrides stall, imem wait and a wrong-path halt.
                    pc_d    = tgt;
                    flush_d = 1'b1;
                end else if (hlt_dec) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (!imem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    pc_d        = pc_plus2;
                    fetch_valid = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // Abandon the pending fetch and go to the new target.
                    pc_d    = tgt;
                    flush_d = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (hlt_dec) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    cnt_d    = '0;
                end else if (imem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    if (!stall) begin
                        pc_d        = pc_plus2;
                        fetch_valid = 1'b1;
                    end
                end else if (cnt_q != WMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALT: begin
                // Frozen until reset; every input is ignored.
                state_d = HALT;
            end
            default: state_d = BOOT;
        endcase
        if (cnt_d == WMAX) timeout_d = 1'b1;
    end

    // State, PC, wait counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; inputs change just after the falling
// edge, outputs are checked 1 time unit later or at the next falling edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_valid, br_taken, hlt_dec, imem_ready;
    logic [15:0] br_target;
    logic [15:0] pc_out, pc_plus2;
    logic        fetch_valid, flush, halted, mem_timeout;

    int n_chk = 0;
    int n_err = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .br_target(br_target), .hlt_dec(hlt_dec),
        .imem_ready(imem_ready), .pc_out(pc_out), .pc_plus2(pc_plus2),
        .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall = 0; br_valid = 0; br_taken = 0; br_target = 16'h0; hlt_dec = 0; imem_ready = 1;
    endtask

    // Advance to the next falling edge, then settle.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic branch_to(input logic [15:0] t);
        idle(); br_valid = 1; br_taken = 1; br_target = t;
        nxt(); idle(); #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #1;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_fv", fetch_valid, 0);
        chk("rst_flags", {flush, halted, mem_timeout}, 3'b000);

        // Boot sequence
        nxt(); rst_n = 1; #1;
        chk("boot_fv", fetch_valid, 0);
        chk("boot_pc", pc_out, 16'h0000);
        nxt(); #1;
        chk("run0_pc", pc_out, 16'h0000);
        chk("run0_fv", fetch_valid, 1);
        nxt(); #1;
        chk("run1_pc", pc_out, 16'h0002);
        chk("pc_plus2", pc_plus2, 16'h0004);
        nxt(); #1;
        chk("run2_pc", pc_out, 16'h0004);

        // Branch with stall, odd target
        branch_to(16'h0010);
        chk("br10_pc", pc_out, 16'h0010);
        chk("br10_flush", flush, 1);
        stall = 1; br_valid = 1; br_taken = 1; br_target = 16'h0101; #1;
        chk("br_fv_low", fetch_valid, 0);
        nxt(); idle(); #1;
        chk("br100_pc", pc_out, 16'h0100);
        chk("br100_flush", flush, 1);
        nxt(); #1;
        chk("flush_pulse_end", flush, 0);
        chk("seq102_pc", pc_out, 16'h0102);

        // Back-to-back redirects
        br_valid = 1; br_taken = 1; br_target = 16'h0200;
        nxt(); #1;
        chk("b2b_pc0", pc_out, 16'h0200);
        chk("b2b_fl0", flush, 1);
        br_target = 16'h0300;
        nxt(); idle(); #1;
        chk("b2b_pc1", pc_out, 16'h0300);
        chk("b2b_fl1", flush, 1);
        nxt(); #1;
        chk("b2b_end", {flush, pc_out}, {1'b0, 16'h0302});

        // Not-taken branch falls through to sequential
        br_valid = 1; br_taken = 0; br_target = 16'h0500; #1;
        chk("nt_fv", fetch_valid, 1);
        nxt(); idle(); #1;
        chk("nt_pc", {flush, pc_out}, {1'b0, 16'h0304});

        // Short imem wait
        branch_to(16'h0030);
        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait3_fv", fetch_valid, 0);
            nxt(); #1;
            chk("wait3_pc", pc_out, 16'h0030);
            chk("wait3_to", mem_timeout, 0);
        end
        imem_ready = 1; #1;
        chk("wait3_done_fv", fetch_valid, 1);
        nxt(); #1;
        chk("wait3_done_pc", pc_out, 16'h0032);

        // Long imem wait: timeout after exactly WAIT_MAX low cycles
        imem_ready = 0;
        for (int i = 0; i < 14; i++) nxt();
        #1;
        chk("to_14", mem_timeout, 0);
        nxt(); #1;
        chk("to_15", mem_timeout, 1);
        nxt(); #1;
        chk("to_16_pc", pc_out, 16'h0032);
        imem_ready = 1;
        nxt(); #1;
        chk("to_resume_pc", pc_out, 16'h0034);
        chk("to_sticky", mem_timeout, 1);

        // Wrap-around and stall hold
        branch_to(16'hFFFE);
        chk("wrap_p2", pc_plus2, 16'h0000);
        nxt(); #1;
        chk("wrap_pc", pc_out, 16'h0000);
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_fv", fetch_valid, 0);
            nxt(); #1;
            chk("stall_pc", pc_out, 16'h0000);
        end
        idle();

        // Async reset in WAIT with timeout set
        imem_ready = 0;
        nxt(); #1;
        chk("pre_rst_to", mem_timeout, 1);
        rst_n = 0; #1;
        chk("wrst_pc", pc_out, 16'h0000);
        chk("wrst_flags", {flush, halted, mem_timeout, fetch_valid}, 4'b0000);
        nxt(); idle(); rst_n = 1; #1;
        chk("wrst_boot_fv", fetch_valid, 0);
        nxt(); #1;
        chk("wrst_run_fv", fetch_valid, 1);

        // Branch squashes a wrong-path halt, then a real halt
        branch_to(16'h0020);
        br_valid = 1; br_taken = 1; br_target = 16'h0040; hlt_dec = 1;
        nxt(); idle(); #1;
        chk("sq_pc", pc_out, 16'h0040);
        chk("sq_halted", halted, 0);
        nxt(); #1;
        chk("sq_seq_pc", pc_out, 16'h0042);
        hlt_dec = 1; #1;
        chk("hlt_fv", fetch_valid, 0);
        nxt(); idle(); #1;
        chk("hlt_halted", halted, 1);
        chk("hlt_pc", pc_out, 16'h0042);
        for (int i = 0; i < 10; i++) begin
            br_valid = 1; br_taken = (i % 2 == 0); br_target = 16'h0080;
            stall = (i % 2 == 1);
            nxt(); #1;
            chk("halt_hold", {halted, fetch_valid, flush, pc_out}, {3'b100, 16'h0042});
        end
        idle();

        // Async reset in HALT
        #1 rst_n = 0; #1;
        chk("hrst_pc", pc_out, 16'h0000);
        chk("hrst_halted", halted, 0);
        nxt(); rst_n = 1;
        nxt(); nxt(); #1;
        chk("hrst_run_pc", pc_out, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
